mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/cpu_types.sv | 24 ++
 rtl/load_align.sv | 30 +++
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types.sv
// Shared types for the memory stage: pipeline control word, MEM FSM states
// and the load/store funct3 size encodings.
package cpu_types;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
  } ctrl_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    DONE     = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word out of a raw load word and
// sign- or zero-extends it according to funct3.
module load_align
  import cpu_types::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = word_i >> {off_i, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = off_i[1] ? word_i[31:16] : word_i[15:0];
    unique case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_W:    data_o = word_i;
      F3_BU:   data_o = {24'd0, byte_v};
      F3_HU:   data_o = {16'd0, half_v};
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues load/store requests, stalls the pipe until a
// load response returns, and aligns/extends the loaded data.
module mem_stage
  import cpu_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ctrl_t       ex_mem_ctrl,
  input  logic [31:0] ex_mem_alu_out,
  input  logic [31:0] ex_mem_rs2_val,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [4:0]  ex_mem_rd,
  input  logic [31:0] ex_mem_pc_plus4,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output ctrl_t       mem_ctrl_out,
  output logic [31:0] mem_alu_out,
  output logic [31:0] load_data,
  output logic [4:0]  rd_out,
  output logic [31:0] pc_plus4_out
);

  mem_state_t  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] aligned;
  logic        access, illegal, misalign, mem_op;

  assign mem_ctrl_out = ex_mem_ctrl;
  assign mem_alu_out  = ex_mem_alu_out;
  assign rd_out       = ex_mem_rd;
  assign pc_plus4_out = ex_mem_pc_plus4;

  // Unsigned sizes are meaningless for stores, so they fault like reserved codes.
  always_comb begin
    access   = ex_mem_ctrl.memread | ex_mem_ctrl.memwrite;
    illegal  = (ex_mem_funct3 == 3'b011) | (ex_mem_funct3 == 3'b110) |
               (ex_mem_funct3 == 3'b111) | (ex_mem_ctrl.memwrite & ex_mem_funct3[2]);
    misalign = ((ex_mem_funct3[1:0] == 2'b01) & ex_mem_alu_out[0]) |
               ((ex_mem_funct3[1:0] == 2'b10) & (ex_mem_alu_out[1:0] != 2'b00));
    mem_fault = access & (illegal | misalign);
    mem_op    = access & ~mem_fault;
  end

  always_comb begin
    dmem_we   = ex_mem_ctrl.memwrite;
    dmem_addr = {ex_mem_alu_out[31:2], 2'b00};
    unique case (ex_mem_funct3[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << ex_mem_alu_out[1:0];
        dmem_wdata = {4{ex_mem_rs2_val[7:0]}};
      end
      2'b01: begin
        dmem_be    = ex_mem_alu_out[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{ex_mem_rs2_val[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = ex_mem_rs2_val;
      end
    endcase
  end

  load_align u_load_align (
    .word_i   (dmem_rsp_rdata),
    .off_i    (ex_mem_alu_out[1:0]),
    .funct3_i (ex_mem_funct3),
    .data_o   (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE:
        if (mem_op && dmem_req_ready && !ex_mem_ctrl.memwrite) state_d = WAIT_RSP;
      WAIT_RSP:
        if (dmem_rsp_valid) begin
          rdata_d = aligned;
          state_d = DONE;
        end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stores are posted: an accepted store does not hold the pipe.
  always_comb begin
    dmem_req_valid = 1'b0;
    mem_stall      = 1'b0;
    load_data      = 32'd0;
    unique case (state_q)
      IDLE: begin
        dmem_req_valid = mem_op;
        mem_stall      = mem_op & ~(ex_mem_ctrl.memwrite & dmem_req_ready);
      end
      WAIT_RSP: mem_stall = 1'b1;
      DONE:     load_data = rdata_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected request handshakes and completed
// loads are queued by the stimulus and checked by an independent monitor.
module tb_mem_stage;
  import cpu_types::*;

  logic        clk = 1'b0;
  logic        rst;
  ctrl_t       ex_mem_ctrl;
  logic [31:0] ex_mem_alu_out, ex_mem_rs2_val, ex_mem_pc_plus4;
  logic [2:0]  ex_mem_funct3;
  logic [4:0]  ex_mem_rd;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rsp_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_rsp_valid, mem_stall, mem_fault;
  ctrl_t       mem_ctrl_out;
  logic [31:0] mem_alu_out, load_data, pc_plus4_out;
  logic [4:0]  rd_out;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_mem_ctrl(ex_mem_ctrl), .ex_mem_alu_out(ex_mem_alu_out),
    .ex_mem_rs2_val(ex_mem_rs2_val), .ex_mem_funct3(ex_mem_funct3), .ex_mem_rd(ex_mem_rd),
    .ex_mem_pc_plus4(ex_mem_pc_plus4), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rsp_rdata(dmem_rsp_rdata), .mem_stall(mem_stall), .mem_fault(mem_fault),
    .mem_ctrl_out(mem_ctrl_out), .mem_alu_out(mem_alu_out), .load_data(load_data),
    .rd_out(rd_out), .pc_plus4_out(pc_plus4_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every handshake and every load leaving the stage must match the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_req_valid && dmem_req_ready) begin
        if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
        else begin
          req_t e;
          e = req_q.pop_front();
          chk("req_we", {31'd0, dmem_we}, {31'd0, e.we});
          chk("req_addr", dmem_addr, e.addr);
          chk("req_be", {28'd0, dmem_be}, {28'd0, e.be});
          chk("req_wdata", dmem_wdata, e.wdata);
        end
      end
      if (ex_mem_ctrl.memread && !mem_stall && !mem_fault) begin
        if (ld_q.size() == 0) chk("unexpected_load", 32'd1, 32'd0);
        else chk("load_result", load_data, ld_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    ex_mem_ctrl    = '0;
    ex_mem_alu_out = 32'h0;
    ex_mem_rs2_val = 32'h0;
    ex_mem_funct3  = 3'b000;
    dmem_req_ready = 1'b1;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] rsp, input logic [31:0] exp, input int delay);
    ex_mem_ctrl = '0; ex_mem_ctrl.memread = 1'b1; ex_mem_ctrl.regwrite = 1'b1;
    ex_mem_alu_out = addr; ex_mem_funct3 = f3; ex_mem_rs2_val = 32'h0;
    dmem_req_ready = 1'b1;
    req_q.push_back('{1'b0, {addr[31:2], 2'b00}, be, 32'h0});
    ld_q.push_back(exp);
    @(negedge clk); chk("ld_issue_stall", {31'd0, mem_stall}, 32'd1);
    cyc();
    for (int i = 0; i < delay; i++) begin
      dmem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("ld_wait_stall", {31'd0, mem_stall}, 32'd1);
      chk("ld_wait_noreq", {31'd0, dmem_req_valid}, 32'd0);
      cyc();
    end
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = rsp;
    @(negedge clk); chk("ld_rsp_stall", {31'd0, mem_stall}, 32'd1);
    cyc();
    dmem_rsp_valid = 1'b0; dmem_rsp_rdata = 32'h0;
    @(negedge clk);
    chk("ld_done_stall", {31'd0, mem_stall}, 32'd0);
    chk("ld_done_noreq", {31'd0, dmem_req_valid}, 32'd0);
    cyc();
    bubble();
    @(negedge clk); chk("ld_after_zero", load_data, 32'd0);
    cyc();
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic [31:0] wd, input int nwait);
    ex_mem_ctrl = '0; ex_mem_ctrl.memwrite = 1'b1;
    ex_mem_alu_out = addr; ex_mem_funct3 = f3; ex_mem_rs2_val = data;
    for (int i = 0; i < nwait; i++) begin
      dmem_req_ready = 1'b0;
      @(negedge clk);
      chk("st_hold_stall", {31'd0, mem_stall}, 32'd1);
      chk("st_hold_valid", {31'd0, dmem_req_valid}, 32'd1);
      chk("st_hold_be", {28'd0, dmem_be}, {28'd0, be});
      chk("st_hold_wdata", dmem_wdata, wd);
      cyc();
    end
    dmem_req_ready = 1'b1;
    req_q.push_back('{1'b1, {addr[31:2], 2'b00}, be, wd});
    @(negedge clk); chk("st_accept_stall", {31'd0, mem_stall}, 32'd0);
    cyc();
    bubble();
  endtask

  task automatic do_fault(input logic rd, input logic [2:0] f3, input logic [31:0] addr);
    ex_mem_ctrl = '0; ex_mem_ctrl.memread = rd; ex_mem_ctrl.memwrite = ~rd;
    ex_mem_alu_out = addr; ex_mem_funct3 = f3; ex_mem_rs2_val = 32'h55AA55AA;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    chk("flt_fault", {31'd0, mem_fault}, 32'd1);
    chk("flt_noreq", {31'd0, dmem_req_valid}, 32'd0);
    chk("flt_nostall", {31'd0, mem_stall}, 32'd0);
    chk("flt_ldzero", load_data, 32'd0);
    cyc();
    bubble();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bubble();
    ex_mem_rd = 5'd7; ex_mem_pc_plus4 = 32'h0000_1004;
    dmem_rsp_valid = 1'b0; dmem_rsp_rdata = 32'h0;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, dmem_req_valid}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_load", load_data, 32'd0);
    chk("pass_rd", {27'd0, rd_out}, 32'd7);
    chk("pass_pc4", pc_plus4_out, 32'h0000_1004);
    cyc();

    do_store(F3_W, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0);
    do_load(F3_B,  32'h103, 4'b1000, 32'h80FF_FF00, 32'hFFFF_FF80, 0);
    do_load(F3_BU, 32'h103, 4'b1000, 32'h80FF_FF00, 32'h0000_0080, 0);
    do_store(F3_H, 32'h102, 32'h0000_1234, 4'b1100, 32'h1234_1234, 3);
    do_store(F3_B, 32'h101, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, 1);
    do_load(F3_H,  32'h202, 4'b1100, 32'h8001_0000, 32'hFFFF_8001, 2);
    do_load(F3_HU, 32'h202, 4'b1100, 32'h8001_0000, 32'h0000_8001, 0);
    do_load(F3_W,  32'h300, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
    do_load(F3_B,  32'h301, 4'b0010, 32'h0000_7F00, 32'h0000_007F, 0);

    do_fault(1'b1, F3_W,   32'h101);
    do_fault(1'b1, F3_H,   32'h103);
    do_fault(1'b1, 3'b011, 32'h100);
    do_fault(1'b0, F3_BU,  32'h100);

    // Load accepted, then reset while waiting; the late response must vanish.
    ex_mem_ctrl = '0; ex_mem_ctrl.memread = 1'b1;
    ex_mem_alu_out = 32'h400; ex_mem_funct3 = F3_W; dmem_req_ready = 1'b1;
    req_q.push_back('{1'b0, 32'h400, 4'b1111, 32'h0});
    @(negedge clk); chk("rstw_issue_stall", {31'd0, mem_stall}, 32'd1);
    cyc();
    rst = 1'b1;
    bubble();
    cyc();
    rst = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("rstw_stall", {31'd0, mem_stall}, 32'd0);
    chk("rstw_valid", {31'd0, dmem_req_valid}, 32'd0);
    chk("rstw_load", load_data, 32'd0);
    cyc();
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("rstw_late_load", load_data, 32'd0);
    chk("rstw_late_stall", {31'd0, mem_stall}, 32'd0);
    cyc();

    chk("req_q_drained", req_q.size(), 32'd0);
    chk("ld_q_drained", ld_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
